vx_secded_dec_pipe: RTL and testbench

- Pipelined, multi-word SECDED decoder with valid/ready handshake, per-word status, saturating error counters and a first-uncorrectable error log.
- Sits between cache data-SRAM read ports and the response path.
- Decodes NUM_WORDS independent codewords per beat, each protecting DATA_BITS data bits.

---
 rtl/vx_secded_dec_pipe.sv | 168 ++++++++++++++++
 tb/tb_vx_secded_dec_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder: NUM_WORDS codewords per beat, valid/ready,
// saturating error counters and first-uncorrectable log. Macro VX_SECDED_INJECT_EN adds error injection.
module vx_secded_dec_pipe #(
  parameter int unsigned DATA_BITS    = 15,
  parameter int unsigned NUM_WORDS    = 4,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned COUNT_BITS   = 16,
  localparam int unsigned HAMMING_BITS = $clog2(DATA_BITS + $clog2(DATA_BITS + 1) + 1),
  localparam int unsigned ENCODED_BITS = DATA_BITS + HAMMING_BITS + 1
) (
  input  logic                              clk,
  input  logic                              reset,
`ifdef VX_SECDED_INJECT_EN
  input  logic                              inj_en,
  input  logic [NUM_WORDS*ENCODED_BITS-1:0] inj_mask,
`endif
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_WORDS*ENCODED_BITS-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]              in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_WORDS*DATA_BITS-1:0]    out_data,
  output logic [TAG_WIDTH-1:0]              out_tag,
  output logic [NUM_WORDS-1:0]              out_corrected,
  output logic [NUM_WORDS-1:0]              out_invalid,
  output logic [COUNT_BITS-1:0]             cnt_corr,
  output logic [COUNT_BITS-1:0]             cnt_uncorr,
  output logic                              err_valid,
  output logic [TAG_WIDTH-1:0]              err_tag,
  output logic [NUM_WORDS-1:0]              err_word,
  input  logic                              stat_clr
);

  localparam int unsigned SUM_W = COUNT_BITS + $clog2(NUM_WORDS + 1);

  typedef logic [ENCODED_BITS-1:0] cw_t;
  typedef logic [HAMMING_BITS-1:0] syn_t;

  // Hamming position of data bit j: j-th position that is not a power of two.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned k;
    k = 0;
    for (int unsigned pos = 1; pos < ENCODED_BITS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (k == j) return pos;
        k++;
      end
    end
    return 1;
  endfunction

  logic                           s1_valid, s1_adv, s2_adv, out_hs;
  cw_t  [NUM_WORDS-1:0]           in_cw, s1_cw, fix_c;
  syn_t [NUM_WORDS-1:0]           syn_c, s1_syn;
  logic [NUM_WORDS-1:0]           par_c, s1_par, corr_c, inv_c;
  logic [TAG_WIDTH-1:0]           s1_tag;
  logic [NUM_WORDS*DATA_BITS-1:0] dat_c;
  logic [SUM_W-1:0]               corr_sum_c, uncorr_sum_c;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid & out_ready;

`ifdef VX_SECDED_INJECT_EN
  assign in_cw = in_data ^ (inj_en ? inj_mask : '0);
`else
  assign in_cw = in_data;
`endif

  // Stage-1 syndrome and overall parity per word
  always_comb begin
    syn_c = '0;
    par_c = '0;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      par_c[w] = ^in_cw[w];
      for (int i = 0; i < int'(ENCODED_BITS) - 1; i++) begin
        for (int p = 0; p < int'(HAMMING_BITS); p++) begin
          if ((((i + 1) >> p) & 1) != 0) syn_c[w][p] = syn_c[w][p] ^ in_cw[w][i];
        end
      end
    end
  end

  // Stage-2 classification and single-bit correction
  always_comb begin
    fix_c  = s1_cw;
    corr_c = '0;
    inv_c  = '0;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      if (s1_syn[w] == '0) begin
        corr_c[w] = s1_par[w];
      end else if (!s1_par[w] || (s1_syn[w] > HAMMING_BITS'(ENCODED_BITS - 1))) begin
        inv_c[w] = 1'b1;
      end else begin
        corr_c[w] = 1'b1;
        for (int i = 0; i < int'(ENCODED_BITS) - 1; i++) begin
          if (s1_syn[w] == HAMMING_BITS'(i + 1)) fix_c[w][i] = ~s1_cw[w][i];
        end
      end
    end
  end

  for (genvar w = 0; w < int'(NUM_WORDS); w++) begin : g_word
    for (genvar j = 0; j < int'(DATA_BITS); j++) begin : g_bit
      localparam int unsigned POS = data_pos(j);
      assign dat_c[w*DATA_BITS + j] = fix_c[w][POS-1];
    end
  end

  assign corr_sum_c   = SUM_W'(cnt_corr) + SUM_W'($countones(out_corrected));
  assign uncorr_sum_c = SUM_W'(cnt_uncorr) + SUM_W'($countones(out_invalid));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_cw         <= '0;
      s1_syn        <= '0;
      s1_par        <= '0;
      s1_tag        <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_tag       <= '0;
      out_corrected <= '0;
      out_invalid   <= '0;
      cnt_corr      <= '0;
      cnt_uncorr    <= '0;
      err_valid     <= 1'b0;
      err_tag       <= '0;
      err_word      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_cw  <= in_cw;
          s1_syn <= syn_c;
          s1_par <= par_c;
          s1_tag <= in_tag;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data      <= dat_c;
          out_tag       <= s1_tag;
          out_corrected <= corr_c;
          out_invalid   <= inv_c;
        end
      end
      // Clear beats a same-cycle handshake; counters saturate at all-ones
      if (stat_clr) begin
        cnt_corr   <= '0;
        cnt_uncorr <= '0;
        err_valid  <= 1'b0;
      end else if (out_hs) begin
        cnt_corr   <= (corr_sum_c[SUM_W-1:COUNT_BITS] != '0) ? '1 : corr_sum_c[COUNT_BITS-1:0];
        cnt_uncorr <= (uncorr_sum_c[SUM_W-1:COUNT_BITS] != '0) ? '1 : uncorr_sum_c[COUNT_BITS-1:0];
        if (!err_valid && (out_invalid != '0)) begin
          err_valid <= 1'b1;
          err_tag   <= out_tag;
          err_word  <= out_invalid;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_secded_dec_pipe.sv
// Self-checking bench for vx_secded_dec_pipe: directed cases then randomized traffic
// against a nearest-codeword reference model with a beat scoreboard.
module tb_vx_secded_dec_pipe;
  localparam int unsigned DB = 15;
  localparam int unsigned NW = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned CB = 4;
  localparam int unsigned HB = 5;
  localparam int unsigned EB = DB + HB + 1;
  localparam int CMAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, stat_clr = 1'b0;
  logic [NW*EB-1:0] in_data = '0;
  logic [TW-1:0] in_tag = '0, out_tag, err_tag;
  logic [NW*DB-1:0] out_data;
  logic [NW-1:0] out_corrected, out_invalid, err_word;
  logic [CB-1:0] cnt_corr, cnt_uncorr;
  logic err_valid;
`ifdef VX_SECDED_INJECT_EN
  logic inj_en = 1'b0;
  logic [NW*EB-1:0] inj_mask = '0;
`endif

  vx_secded_dec_pipe #(.DATA_BITS(DB), .NUM_WORDS(NW), .TAG_WIDTH(TW), .COUNT_BITS(CB)) dut (
    .clk(clk), .reset(reset),
`ifdef VX_SECDED_INJECT_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_corrected(out_corrected), .out_invalid(out_invalid),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr),
    .err_valid(err_valid), .err_tag(err_tag), .err_word(err_word), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW*DB-1:0] data;
    logic [TW-1:0]    tag;
    logic [NW-1:0]    corr;
    logic [NW-1:0]    inv;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, failures = 0;
  int m_corr = 0, m_uncorr = 0;
  logic m_ev = 1'b0;
  logic [TW-1:0] m_etag = '0;
  logic [NW-1:0] m_eword = '0;
  logic [NW*EB-1:0] zero_beat = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder: data in non-power-of-two positions, even-parity check bits, overall parity
  function automatic logic [EB-1:0] encode(input logic [DB-1:0] d);
    logic [EB-1:0] c;
    int k;
    logic x;
    c = '0;
    k = 0;
    for (int pos = 1; pos < int'(EB); pos++)
      if ((pos & (pos - 1)) != 0) begin c[pos-1] = d[k]; k++; end
    for (int p = 0; p < int'(HB); p++) begin
      x = 1'b0;
      for (int pos = 1; pos < int'(EB); pos++)
        if (((pos >> p) & 1) != 0) x = x ^ c[pos-1];
      c[(1 << p) - 1] = x;
    end
    c[EB-1] = ^c[EB-2:0];
    return c;
  endfunction

  function automatic logic [DB-1:0] extract(input logic [EB-1:0] c);
    logic [DB-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < int'(EB); pos++)
      if ((pos & (pos - 1)) != 0) begin d[k] = c[pos-1]; k++; end
    return d;
  endfunction

  // Nearest-codeword decode: valid codeword, or one flip away, else uncorrectable
  task automatic decode_word(input logic [EB-1:0] c, output logic [DB-1:0] d,
                             output logic corr, output logic inv);
    logic [EB-1:0] t;
    d = extract(c);
    corr = 1'b0;
    inv = 1'b0;
    if (encode(extract(c)) != c) begin
      inv = 1'b1;
      for (int i = 0; i < int'(EB); i++) begin
        t = c;
        t[i] = ~t[i];
        if (inv && encode(extract(t)) == t) begin
          d = extract(t);
          corr = 1'b1;
          inv = 1'b0;
        end
      end
    end
  endtask

  task automatic model_beat(input logic [NW*EB-1:0] cw, input logic [TW-1:0] tag, output beat_t b);
    logic [DB-1:0] d;
    logic c, v;
    b.tag = tag;
    b.data = '0;
    b.corr = '0;
    b.inv = '0;
    for (int w = 0; w < int'(NW); w++) begin
      decode_word(cw[w*EB +: EB], d, c, v);
      b.data[w*DB +: DB] = d;
      b.corr[w] = c;
      b.inv[w] = v;
    end
  endtask

  // nflip < 0 gives an arbitrary random word
  function automatic logic [EB-1:0] make_word(input int nflip);
    logic [EB-1:0] c, m;
    if (nflip < 0) return EB'($urandom);
    c = encode(DB'($urandom));
    m = '0;
    while ($countones(m) < nflip) m[$urandom_range(EB-1, 0)] = 1'b1;
    return c ^ m;
  endfunction

  // n == -2 picks a random error mix per word
  function automatic logic [NW*EB-1:0] make_beat(input int n);
    logic [NW*EB-1:0] v;
    int r, k;
    for (int w = 0; w < int'(NW); w++) begin
      k = n;
      if (n == -2) begin
        r = $urandom_range(99, 0);
        k = (r < 40) ? 0 : (r < 70) ? 1 : (r < 90) ? 2 : (r < 95) ? 3 : -1;
      end
      v[w*EB +: EB] = make_word(k);
    end
    return v;
  endfunction

  function automatic logic [NW*EB-1:0] w0(input logic [EB-1:0] c);
    logic [NW*EB-1:0] v;
    v = '0;
    v[EB-1:0] = c;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = make_beat(-2);
    out_ready = 1'b1;
    stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_corr = 0;
    m_uncorr = 0;
    m_ev = 1'b0;
    m_etag = '0;
    m_eword = '0;
  endtask

  // One clock: drive at negedge, check outputs, advance model over the coming edge
  task automatic cycle(input logic iv, input logic [NW*EB-1:0] id, input logic [TW-1:0] it,
                       input logic ordy, input logic clr);
    beat_t f, nb;
    logic ir_exp;
    in_valid = iv;
    in_data = id;
    in_tag = it;
    out_ready = ordy;
    stat_clr = clr;
    #1;
    ir_exp = ordy || (exp_q.size() < 2);
    chk("in_ready", in_ready, ir_exp);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else begin
        f = exp_q[0];
        chk("out_data", out_data, f.data);
        chk("out_tag", out_tag, f.tag);
        chk("out_corrected", out_corrected, f.corr);
        chk("out_invalid", out_invalid, f.inv);
      end
    end
    chk("cnt_corr", cnt_corr, m_corr);
    chk("cnt_uncorr", cnt_uncorr, m_uncorr);
    chk("err_valid", err_valid, m_ev);
    chk("err_tag", err_tag, m_etag);
    chk("err_word", err_word, m_eword);
    if (out_valid && ordy && exp_q.size() > 0) begin
      f = exp_q.pop_front();
      if (!clr) begin
        m_corr = (m_corr + $countones(f.corr) > CMAX) ? CMAX : m_corr + $countones(f.corr);
        m_uncorr = (m_uncorr + $countones(f.inv) > CMAX) ? CMAX : m_uncorr + $countones(f.inv);
        if (!m_ev && f.inv != '0) begin
          m_ev = 1'b1;
          m_etag = f.tag;
          m_eword = f.inv;
        end
      end
    end
    if (clr) begin
      m_corr = 0;
      m_uncorr = 0;
      m_ev = 1'b0;
    end
    if (iv && ir_exp) begin
      model_beat(id, it, nb);
      exp_q.push_back(nb);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, zero_beat, '0, 1'b1, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_tag", out_tag, '0);
    chk("rst_flags", {out_corrected, out_invalid}, '0);
    chk("rst_counters", {cnt_corr, cnt_uncorr}, '0);
    chk("rst_err", {err_valid, err_tag, err_word}, '0);

    // Clean zero beat: exactly two cycles of latency
    cycle(1'b1, zero_beat, 8'h11, 1'b1, 1'b0);
    chk("lat_cycle1", out_valid, 1'b0);
    cycle(1'b0, zero_beat, '0, 1'b1, 1'b0);
    chk("lat_cycle2", out_valid, 1'b1);
    chk("clean_tag", out_tag, 8'h11);
    chk("clean_data", out_data, '0);
    idle(1);

    // Single data-bit error at index 2
    cycle(1'b1, w0(EB'(1) << 2), 8'h22, 1'b1, 1'b0);
    idle(1);
    chk("single_corr", out_corrected, 4'b0001);
    chk("single_data", out_data, '0);
    idle(1);
    chk("single_cnt", cnt_corr, 1);

    // Double error at indices 2 and 4: uncorrectable, raw data passes
    cycle(1'b1, w0((EB'(1) << 2) | (EB'(1) << 4)), 8'h33, 1'b1, 1'b0);
    idle(1);
    chk("double_inv", out_invalid, 4'b0001);
    chk("double_corr", out_corrected, 4'b0000);
    chk("double_data", out_data[1:0], 2'b11);
    idle(1);
    chk("double_log", {err_valid, err_tag, err_word}, {1'b1, 8'h33, 4'b0001});
    chk("double_cnt", cnt_uncorr, 1);

    // Overall parity bit only
    cycle(1'b1, w0(EB'(1) << (EB - 1)), 8'h44, 1'b1, 1'b0);
    idle(1);
    chk("parity_corr", out_corrected, 4'b0001);
    chk("parity_data", out_data, '0);
    idle(1);

    // Backpressure: third beat stalls until out_ready returns
    cycle(1'b1, make_beat(0), 8'h51, 1'b0, 1'b0);
    cycle(1'b1, make_beat(0), 8'h52, 1'b0, 1'b0);
    cycle(1'b1, make_beat(0), 8'h53, 1'b0, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    cycle(1'b1, make_beat(0), 8'h53, 1'b0, 1'b0);
    cycle(1'b1, make_beat(0), 8'h53, 1'b1, 1'b0);
    idle(3);

    // Saturation: 16 more corrected words on a 4-bit counter
    for (int i = 0; i < 4; i++) cycle(1'b1, make_beat(1), TW'(8'h60 + i), 1'b1, 1'b0);
    idle(3);
    chk("sat_cnt_corr", cnt_corr, CMAX);
    chk("sat_cnt_uncorr", cnt_uncorr, 1);

    // Clear coinciding with a handshake wins
    cycle(1'b1, make_beat(2), 8'h70, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, zero_beat, '0, 1'b1, 1'b1);
    chk("clr_counters", {cnt_corr, cnt_uncorr}, '0);
    chk("clr_err_valid", err_valid, 1'b0);

    // Randomized traffic with a reset while beats are in flight
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle(($urandom_range(3, 0) != 0), make_beat(-2), TW'($urandom),
            ($urandom_range(3, 0) != 0), ($urandom_range(39, 0) == 0));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    chk("drain_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
